div: RTL and testbench



---
 rtl/div_pkg.sv | 6 +
 rtl/div_if.sv | 14 +
 rtl/div_step.sv | 16 +
 rtl/div.sv | 64 ++++++
 tb/tb_div.sv | 128 ++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and iteration constants for the divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX} div_state_t;
  localparam int DIV_STEPS = 32;
  localparam int CNT_W = 5;
endpackage

// File: rtl/div_if.sv
// div_if: control-unit handshake and operand/result bus of the divider
interface div_if #(parameter int WIDTH = 32);
  logic load;
  logic is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic busy;
  logic done;
  logic div_zero;
  modport master (output load, is_signed, dividend, divisor, input hi, lo, busy, done, div_zero);
  modport slave (input load, is_signed, dividend, divisor, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division iteration on {rem, quo}
module div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_n,
  output logic [WIDTH-1:0] quo_n
);
  logic [WIDTH+1:0] sh, diff;
  always_comb begin
    sh = {rem, quo[WIDTH-1]};
    diff = sh - {2'b00, dvs};
    rem_n = diff[WIDTH+1] ? sh[WIDTH:0] : diff[WIDTH:0];
    quo_n = {quo[WIDTH-2:0], ~diff[WIDTH+1]};
  end
endmodule

// File: rtl/div.sv
// div: sequential restoring divider for DIV/DIVU, quotient to lo, remainder to hi
module div import div_pkg::*; #(parameter int WIDTH = 32) (
  input logic Clock,
  input logic reset,
  div_if.slave bus
);
  div_state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0] rem, rem_n;
  logic [WIDTH-1:0] quo, quo_n, dvs, hi, lo;
  logic qneg, rneg, busy, done, div_zero, last;
  div_step #(.WIDTH(WIDTH)) u_step (.rem(rem), .quo(quo), .dvs(dvs), .rem_n(rem_n), .quo_n(quo_n));
  assign last = cnt == CNT_W'(DIV_STEPS - 1);
  always_comb begin
    nxt = (state == IDLE) ? (bus.load ? RUN : IDLE) :
          (state == RUN)  ? (last ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      hi <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && bus.load) begin
        quo <= (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
        dvs <= (bus.is_signed && bus.divisor[WIDTH-1]) ? -bus.divisor : bus.divisor;
        qneg <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
        rneg <= bus.is_signed & bus.dividend[WIDTH-1];
        rem <= '0;
        cnt <= '0;
        busy <= 1'b1;
      end else if (state == RUN) begin
        rem <= rem_n;
        quo <= quo_n;
        cnt <= cnt + CNT_W'(1);
      end else if (state == FIX) begin
        // remainder takes the dividend's sign: truncating division
        lo <= qneg ? -quo : quo;
        hi <= rneg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        div_zero <= dvs == '0;
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
  assign bus.hi = hi;
  assign bus.lo = lo;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.div_zero = div_zero;
endmodule

// File: tb/tb_div.sv
// tb_div: randomized self-checking bench for div against an arithmetic model
module tb_div;
  logic Clock, reset;
  div_if #(.WIDTH(32)) bus ();
  div #(.WIDTH(32)) dut (.Clock(Clock), .reset(reset), .bus(bus));
  int n_chk, n_fail, done_cnt, exp_done;
  logic [31:0] exp_hi, exp_lo;
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(negedge Clock) if (bus.done) done_cnt++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 0) begin
      q = (sgn && a[31]) ? 32'h1 : 32'hFFFFFFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask
  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [31:0] q, r;
    int lat;
    model(sgn, a, b, q, r);
    check("hold_hi", bus.hi, exp_hi);
    check("hold_lo", bus.lo, exp_lo);
    bus.load = 1'b1;
    bus.is_signed = sgn;
    bus.dividend = a;
    bus.divisor = b;
    @(posedge Clock); #1;
    bus.load = 1'b0;
    bus.dividend = $urandom;
    bus.divisor = $urandom;
    bus.is_signed = 1'($urandom);
    check("busy_start", 32'(bus.busy), 32'd1);
    check("done_low", 32'(bus.done), 32'd0);
    lat = 41;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clock); #1;
      bus.load = poke && k == 10;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    bus.load = 1'b0;
    exp_hi = r;
    exp_lo = q;
    exp_done++;
    check("latency", 32'(lat), 32'd33);
    check("lo", bus.lo, q);
    check("hi", bus.hi, r);
    check("div_zero", 32'(bus.div_zero), 32'(b == 0));
    check("busy_end", 32'(bus.busy), 32'd0);
  endtask
  initial begin
    n_chk = 0; n_fail = 0; done_cnt = 0; exp_done = 0;
    exp_hi = 0; exp_lo = 0;
    bus.load = 0; bus.is_signed = 0; bus.dividend = 0; bus.divisor = 0;
    reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_dz", 32'(bus.div_zero), 0);
    reset = 1'b0;
    @(posedge Clock); #1;
    do_div(0, 100, 7, 0);
    do_div(1, -32'sd7, 2, 0);
    do_div(1, 7, -32'sd2, 0);
    do_div(0, 32'hFFFFFFFF, 0, 0);
    do_div(1, 5, 0, 0);
    do_div(1, -32'sd5, 0, 0);
    do_div(1, 32'h80000000, 32'hFFFFFFFF, 0);
    do_div(0, 32'h80000000, 32'hFFFFFFFF, 0);
    do_div(0, 100, 7, 1);
    check("lo_poke", bus.lo, 14);
    repeat (3) @(posedge Clock);
    #1;
    check("done_once", 32'(done_cnt), 32'(exp_done));
    bus.load = 1'b1; bus.is_signed = 0; bus.dividend = 1000; bus.divisor = 3;
    @(posedge Clock); #1;
    bus.load = 1'b0;
    repeat (19) @(posedge Clock);
    #2 reset = 1'b1;
    #1;
    check("mid_busy", 32'(bus.busy), 0);
    check("mid_done", 32'(bus.done), 0);
    check("mid_hi", bus.hi, 0);
    check("mid_lo", bus.lo, 0);
    @(posedge Clock); #1;
    reset = 1'b0;
    exp_hi = 0; exp_lo = 0;
    repeat (40) @(posedge Clock);
    #1;
    check("no_done_rst", 32'(done_cnt), 32'(exp_done));
    do_div(0, 100, 7, 0);
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 3)) : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 1000)));
      do_div(1'($urandom), a, b, 0);
      repeat ($urandom_range(0, 2)) @(posedge Clock);
      #0;
    end
    repeat (2) @(posedge Clock);
    #1;
    check("done_total", 32'(done_cnt), 32'(exp_done));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
